// File: rtl/arf_pkg.sv
// +----------------------------------------------------------------------+
// | arf_pkg : shared widths, clear-sequencer states and popcount helper  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package arf_pkg;

  localparam int AR_SIZE_DEF = 6;
  localparam int DATA_W_DEF  = 32;
  localparam int MAX_WR      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

  // Callers zero-extend their NUM_WR-bit accept vector to MAX_WR bits.
  function automatic logic [31:0] popcount(input logic [MAX_WR-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < MAX_WR; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arf_wr_resolve.sv
// +----------------------------------------------------------------------+
// | arf_wr_resolve : per-entry write select, youngest retire port wins   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module arf_wr_resolve
  import arf_pkg::*;
#(
  parameter int AR_SIZE  = AR_SIZE_DEF,
  parameter int AR_ARRAY = 64,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR*AR_SIZE-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]  wr_data,
  input  logic                      wr_ready,
  output logic [AR_ARRAY-1:0]       ent_we,
  output logic [DATA_W-1:0]         ent_data [AR_ARRAY]
);

  // Ascending port scan: a later (younger) match overrides an earlier one.
  always_comb begin
    for (int e = 0; e < AR_ARRAY; e++) begin
      ent_we[e]   = 1'b0;
      ent_data[e] = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_ready &&
            (wr_addr[j*AR_SIZE +: AR_SIZE] == AR_SIZE'(e)) &&
            !((ZERO_REG != 0) && (e == 0))) begin
          ent_we[e]   = 1'b1;
          ent_data[e] = wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/arf_multiport.sv
// +----------------------------------------------------------------------+
// | arf_multiport : multi-port architectural register file with clear    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module arf_multiport
  import arf_pkg::*;
#(
  parameter int AR_SIZE  = AR_SIZE_DEF,
  parameter int AR_ARRAY = 64,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_RD-1:0]         rd_en,
  input  logic [NUM_RD*AR_SIZE-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]         rd_valid,
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR*AR_SIZE-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]  wr_data,
  output logic                      wr_ready,
  input  logic                      clr_req,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic [31:0]               retire_cnt
);

  localparam logic [AR_SIZE:0]   ARRAY_LIM = (AR_SIZE+1)'(AR_ARRAY);
  localparam logic [AR_SIZE-1:0] LAST_IDX  = AR_SIZE'(AR_ARRAY - 1);

  clr_state_t         state;
  clr_state_t         nxt_state;
  logic [AR_SIZE-1:0] clr_idx;
  logic [AR_SIZE-1:0] nxt_idx;

  logic [DATA_W-1:0]  mem      [AR_ARRAY];
  logic [AR_ARRAY-1:0] ent_we;
  logic [DATA_W-1:0]  ent_data [AR_ARRAY];
  logic [DATA_W-1:0]  rd_val   [NUM_RD];
  logic [NUM_WR-1:0]  accepted;

  assign wr_ready = (state != ST_CLEAR);
  assign clr_busy = (state == ST_CLEAR);
  assign clr_done = (state == ST_DONE);
  assign accepted = wr_en & {NUM_WR{wr_ready}};

  arf_wr_resolve #(
    .AR_SIZE  (AR_SIZE),
    .AR_ARRAY (AR_ARRAY),
    .DATA_W   (DATA_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_resolve (
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .ent_we   (ent_we),
    .ent_data (ent_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      clr_idx <= '0;
    end else begin
      state   <= nxt_state;
      clr_idx <= nxt_idx;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_idx   = clr_idx;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          nxt_state = ST_CLEAR;
          nxt_idx   = '0;
        end
      end
      ST_CLEAR: begin
        nxt_idx = clr_idx + 1'b1;
        if (clr_idx == LAST_IDX) begin
          nxt_state = ST_DONE;
          nxt_idx   = '0;
        end
      end
      ST_DONE: begin
        nxt_state = clr_req ? ST_CLEAR : ST_IDLE;
        nxt_idx   = '0;
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_idx   = '0;
      end
    endcase
  end

  // Writes are blocked by wr_ready during CLEAR, so the clear never races a retire.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int e = 0; e < AR_ARRAY; e++) begin
        mem[e] <= '0;
      end
    end else begin
      for (int e = 0; e < AR_ARRAY; e++) begin
        if (clr_busy && (clr_idx == AR_SIZE'(e))) begin
          mem[e] <= '0;
        end else if (ent_we[e]) begin
          mem[e] <= ent_data[e];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retire_cnt <= '0;
    end else begin
      retire_cnt <= retire_cnt + popcount(MAX_WR'(accepted));
    end
  end

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AR_SIZE-1:0] ra;
      assign ra = rd_addr[k*AR_SIZE +: AR_SIZE];

      // Zero register and out-of-range addresses read as 0 and never take a bypass.
      always_comb begin
        rd_val[k] = '0;
        if (({1'b0, ra} < ARRAY_LIM) && !((ZERO_REG != 0) && (ra == '0))) begin
          rd_val[k] = ((BYPASS != 0) && ent_we[ra]) ? ent_data[ra] : mem[ra];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (rd_en[k]) begin
          rd_valid[k]                 <= !clr_busy;
          rd_data[k*DATA_W +: DATA_W] <= clr_busy ? '0 : rd_val[k];
        end else begin
          rd_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arf_multiport.sv
// +----------------------------------------------------------------------+
// | tb_arf_multiport : directed self-checking bench for arf_multiport    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_arf_multiport;

  logic         clk;
  logic         rstn;
  logic [3:0]   rd_en;
  logic [23:0]  rd_addr;
  logic [1:0]   wr_en;
  logic [11:0]  wr_addr;
  logic [63:0]  wr_data;
  logic         clr_req;

  logic [127:0] rd_data,  rd_data_nb;
  logic [3:0]   rd_valid, rd_valid_nb;
  logic         wr_ready, wr_ready_nb;
  logic         clr_busy, clr_busy_nb;
  logic         clr_done, clr_done_nb;
  logic [31:0]  retire_cnt, retire_cnt_nb;

  int total = 0;
  int bad   = 0;
  int done_seen;

  arf_multiport #(.BYPASS(1)) dut (
    .clk(clk), .rstn(rstn), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .retire_cnt(retire_cnt)
  );

  arf_multiport #(.BYPASS(0)) dut_nb (
    .clk(clk), .rstn(rstn), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_nb), .rd_valid(rd_valid_nb), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready_nb),
    .clr_req(clr_req), .clr_busy(clr_busy_nb), .clr_done(clr_done_nb),
    .retire_cnt(retire_cnt_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] port(input logic [127:0] d, input int k);
    return d[k*32 +: 32];
  endfunction

  task automatic set_rd(input int k, input logic [5:0] a);
    rd_addr[k*6 +: 6] = a;
  endtask

  task automatic set_wr(input int j, input logic [5:0] a, input logic [31:0] d);
    wr_addr[j*6 +: 6]  = a;
    wr_data[j*32 +: 32] = d;
  endtask

  initial begin
    rstn = 1'b0; rd_en = '0; rd_addr = '0; wr_en = '0;
    wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    #12;
    check("rst_wr_ready",  {31'd0, wr_ready}, 32'd1);
    check("rst_clr_busy",  {31'd0, clr_busy}, 32'd0);
    check("rst_clr_done",  {31'd0, clr_done}, 32'd0);
    check("rst_retire",    retire_cnt, 32'd0);
    check("rst_rd_valid",  {28'd0, rd_valid}, 32'd0);

    // 1: reset then read
    rstn = 1'b1;
    rd_en = 4'b1111; set_rd(0, 6'd1); set_rd(1, 6'd2); set_rd(2, 6'd3); set_rd(3, 6'd63);
    tick();
    check("t1_rd_valid", {28'd0, rd_valid}, 32'hF);
    for (int k = 0; k < 4; k++) check("t1_rd_data", port(rd_data, k), 32'd0);
    check("t1_retire", retire_cnt, 32'd0);

    // 2: same-address collision, port 1 wins
    rd_en = 4'b0000;
    wr_en = 2'b11; set_wr(0, 6'd5, 32'h11); set_wr(1, 6'd5, 32'h22);
    tick();
    check("t2_retire", retire_cnt, 32'd2);
    wr_en = 2'b00;
    rd_en = 4'b0001; set_rd(0, 6'd5);
    tick();
    check("t2_reg5", port(rd_data, 0), 32'h22);
    check("t2_rd_valid", {28'd0, rd_valid}, 32'h1);

    // 3: bypass vs read-old
    wr_en = 2'b01; set_wr(0, 6'd7, 32'hABCD);
    rd_en = 4'b0001; set_rd(0, 6'd7);
    tick();
    check("t3_bypass",  port(rd_data, 0), 32'hABCD);
    check("t3_readold", port(rd_data_nb, 0), 32'd0);
    check("t3_retire",  retire_cnt, 32'd3);
    wr_en = 2'b00;
    tick();
    check("t3_nb_after", port(rd_data_nb, 0), 32'hABCD);
    wr_en = 2'b11; set_wr(0, 6'd9, 32'h1); set_wr(1, 6'd9, 32'h2);
    rd_en = 4'b0010; set_rd(1, 6'd9);
    tick();
    check("t3_bypass_prio", port(rd_data, 1), 32'h2);
    check("t3_nb_prio",     port(rd_data_nb, 1), 32'd0);
    check("t3_retire2",     retire_cnt, 32'd5);

    // 4: zero register, plus hold of an idle port
    wr_en = 2'b10; set_wr(1, 6'd0, 32'hFFFF);
    rd_en = 4'b0100; set_rd(2, 6'd0);
    tick();
    check("t4_zero_bypass", port(rd_data, 2), 32'd0);
    check("t4_retire",      retire_cnt, 32'd6);
    check("t4_hold_data",   port(rd_data, 1), 32'h2);
    check("t4_hold_valid",  {28'd0, rd_valid}, 32'h4);
    wr_en = 2'b00;
    rd_en = 4'b0001; set_rd(0, 6'd0);
    tick();
    check("t4_zero_read", port(rd_data, 0), 32'd0);

    // 5: fill 1..63, then clear
    rd_en = 4'b0000;
    for (int i = 1; i <= 63; i += 2) begin
      set_wr(0, 6'(i), 32'(i));
      if (i < 63) begin
        set_wr(1, 6'(i + 1), 32'(i + 1));
        wr_en = 2'b11;
      end else begin
        wr_en = 2'b01;
      end
      tick();
    end
    wr_en = 2'b00;
    check("t5_fill_retire", retire_cnt, 32'd69);
    rd_en = 4'b1111; set_rd(0, 6'd10); set_rd(1, 6'd33); set_rd(2, 6'd63); set_rd(3, 6'd5);
    tick();
    check("t5_fill_r10", port(rd_data, 0), 32'd10);
    check("t5_fill_r33", port(rd_data, 1), 32'd33);
    check("t5_fill_r63", port(rd_data, 2), 32'd63);
    check("t5_fill_r5",  port(rd_data, 3), 32'd5);

    rd_en = 4'b0000;
    clr_req = 1'b1; wr_en = 2'b01; set_wr(0, 6'd1, 32'h55);
    tick();
    clr_req = 1'b0;
    check("t5_req_cycle_retire", retire_cnt, 32'd70);
    for (int c = 1; c <= 64; c++) begin
      check("t5_win_ready", {31'd0, wr_ready}, 32'd0);
      check("t5_win_busy",  {31'd0, clr_busy}, 32'd1);
      check("t5_win_done",  {31'd0, clr_done}, 32'd0);
      if (c >= 2) begin
        check("t5_win_valid", {28'd0, rd_valid}, 32'd0);
        check("t5_win_data",  port(rd_data, 1), 32'd0);
      end
      wr_en = 2'b11; set_wr(0, 6'd2, 32'hDEAD); set_wr(1, 6'd3, 32'hBEEF);
      rd_en = 4'b1111;
      tick();
    end
    check("t5_done",        {31'd0, clr_done}, 32'd1);
    check("t5_done_busy",   {31'd0, clr_busy}, 32'd0);
    check("t5_done_ready",  {31'd0, wr_ready}, 32'd1);
    check("t5_done_retire", retire_cnt, 32'd70);
    check("t5_done_valid",  {28'd0, rd_valid}, 32'd0);
    wr_en = 2'b00;
    set_rd(0, 6'd1); set_rd(1, 6'd10); set_rd(2, 6'd33); set_rd(3, 6'd63);
    tick();
    check("t5_post_done", {31'd0, clr_done}, 32'd0);
    check("t5_post_valid", {28'd0, rd_valid}, 32'hF);
    for (int k = 0; k < 4; k++) check("t5_post_data", port(rd_data, k), 32'd0);
    rd_en = 4'b0000; set_rd(0, 6'd2);
    rd_en = 4'b0001;
    tick();
    check("t5_ignored_wr", port(rd_data, 0), 32'd0);

    // 6: reset in the middle of a clear
    rd_en = 4'b0000;
    wr_en = 2'b01; set_wr(0, 6'd3, 32'h33);
    tick();
    wr_en = 2'b00;
    check("t6_pre_retire", retire_cnt, 32'd71);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    check("t6_mid_busy", {31'd0, clr_busy}, 32'd1);
    rstn = 1'b0;
    #2;
    check("t6_rst_ready",  {31'd0, wr_ready}, 32'd1);
    check("t6_rst_busy",   {31'd0, clr_busy}, 32'd0);
    check("t6_rst_done",   {31'd0, clr_done}, 32'd0);
    check("t6_rst_retire", retire_cnt, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (clr_done) done_seen++;
    end
    check("t6_no_done", 32'(done_seen), 32'd0);
    rd_en = 4'b1111; set_rd(0, 6'd3); set_rd(1, 6'd10); set_rd(2, 6'd33); set_rd(3, 6'd63);
    tick();
    check("t6_rd_valid", {28'd0, rd_valid}, 32'hF);
    for (int k = 0; k < 4; k++) check("t6_rd_data", port(rd_data, k), 32'd0);
    check("t6_ready_idle", {31'd0, wr_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
